// File: rtl/wb_port_scheduler_if.sv
// rtl/wb_port_scheduler_if.sv - WB / LL / ID / RegFile-write signal bundle for the port scheduler
interface wb_port_scheduler_if #(
    parameter int XLEN = 32
);
    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic [4:0]      id_rs1;
    logic [4:0]      id_rs2;
    logic [4:0]      id_rd;
    logic            id_we;
    logic            id_ll_op;
    logic            ll_issue;
    logic            ll_resp_valid;
    logic [4:0]      ll_resp_rd;
    logic [XLEN-1:0] ll_resp_data;
    logic            ll_resp_ready;
    logic            id_stall;
    logic            pipe_hold;
    logic            rf_we;
    logic [4:0]      rf_waddr;
    logic [XLEN-1:0] rf_wdata;
    logic            err_unexp;

    modport master (
        output wb_valid, wb_rd, wb_data, id_rs1, id_rs2, id_rd, id_we, id_ll_op, ll_issue,
               ll_resp_valid, ll_resp_rd, ll_resp_data,
        input  ll_resp_ready, id_stall, pipe_hold, rf_we, rf_waddr, rf_wdata, err_unexp
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data, id_rs1, id_rs2, id_rd, id_we, id_ll_op, ll_issue,
               ll_resp_valid, ll_resp_rd, ll_resp_data,
        output ll_resp_ready, id_stall, pipe_hold, rf_we, rf_waddr, rf_wdata, err_unexp
    );
endinterface

// File: rtl/wb_port_scheduler.sv
// rtl/wb_port_scheduler.sv - RegFile write-port arbiter between MEM/WB and a long-latency unit
module wb_port_scheduler #(
    parameter int XLEN       = 32,
    parameter int BUF_DEPTH  = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                clk,
    input  logic                rst,
    wb_port_scheduler_if.slave  bus
);
    localparam int AW = $clog2(BUF_DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);

    logic [31:0]     pend;
    logic [31:0]     pend_nxt;
    logic [AW:0]     wptr;
    logic [AW:0]     rptr;
    logic [SW-1:0]   starve_cnt;
    logic [4:0]      buf_rd   [BUF_DEPTH];
    logic [XLEN-1:0] buf_data [BUF_DEPTH];

    logic empty, full, wb_take, pop, bypass, push, ll_write;
    logic [4:0] ll_wr_rd;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);

    // The count only advances while the FIFO holds data, so a hold always has a head to pop.
    assign bus.pipe_hold     = (starve_cnt == SW'(STARVE_MAX));
    assign bus.ll_resp_ready = !full;

    assign wb_take  = bus.wb_valid && (bus.wb_rd != 5'd0) && !bus.pipe_hold;
    assign pop      = !wb_take && !empty;
    assign bypass   = !wb_take && empty && bus.ll_resp_valid;
    assign push     = bus.ll_resp_valid && !full && !bypass;
    assign ll_write = pop || bypass;
    assign ll_wr_rd = pop ? buf_rd[rptr[AW-1:0]] : bus.ll_resp_rd;

    always_comb begin
        bus.rf_we    = 1'b0;
        bus.rf_waddr = 5'd0;
        bus.rf_wdata = '0;
        if (wb_take) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = bus.wb_rd;
            bus.rf_wdata = bus.wb_data;
        end else if (pop) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = buf_rd[rptr[AW-1:0]];
            bus.rf_wdata = buf_data[rptr[AW-1:0]];
        end else if (bypass) begin
            bus.rf_we    = 1'b1;
            bus.rf_waddr = bus.ll_resp_rd;
            bus.rf_wdata = bus.ll_resp_data;
        end
    end

    assign bus.id_stall = ((bus.id_rs1 != 5'd0) && pend[bus.id_rs1])
                        | ((bus.id_rs2 != 5'd0) && pend[bus.id_rs2])
                        | (bus.id_we && (bus.id_rd != 5'd0) && pend[bus.id_rd])
                        | (bus.id_ll_op && full);

    // Clear before set so a same-cycle issue to the retiring register keeps it pending.
    always_comb begin
        pend_nxt = pend;
        if (ll_write)
            pend_nxt[ll_wr_rd] = 1'b0;
        if (bus.ll_issue && (bus.id_rd != 5'd0))
            pend_nxt[bus.id_rd] = 1'b1;
        pend_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend          <= '0;
            wptr          <= '0;
            rptr          <= '0;
            starve_cnt    <= '0;
            bus.err_unexp <= 1'b0;
        end else begin
            pend <= pend_nxt;
            if (push)
                wptr <= wptr + 1'b1;
            if (pop)
                rptr <= rptr + 1'b1;
            if (empty || pop)
                starve_cnt <= '0;
            else
                starve_cnt <= starve_cnt + 1'b1;
            if (ll_write && (ll_wr_rd != 5'd0) && !pend[ll_wr_rd])
                bus.err_unexp <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            buf_rd[wptr[AW-1:0]]   <= bus.ll_resp_rd;
            buf_data[wptr[AW-1:0]] <= bus.ll_resp_data;
        end
    end
endmodule
